squeezer_rule_pipe: RTL and testbench

Pipelined, multi-lane squeezer rule generator for the carry-save modular multiplier. For each lane it normalises the top two bits of the sum/carry pair (p, q) with a topup step and selects a 3-bit squeeze rule from the normalised bits and the r2 flag. Each pipeline stage carries a valid/ready handshake. The block sits between the carry-save accumulator and the squeezer datapath and replaces the single-lane combinational rule decoder in the pipelined build.

---
 rtl/squeezer_pkg.sv | 30 +++
 rtl/squeezer_rule_pipe_if.sv | 34 +++
 rtl/squeezer_rule_lane.sv | 41 ++++
 rtl/squeezer_rule_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_squeezer_rule_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/squeezer_pkg.sv
// Shared definitions for the squeezer rule pipeline: rule codes, rule type
// and the topup helper that normalises a sum/carry top-bit pair.
package squeezer_pkg;

    localparam int RULE_W = 3;

    typedef enum logic [RULE_W-1:0] {
        RULE_IDLE = 3'd0,
        RULE_1    = 3'd1,
        RULE_2    = 3'd2,
        RULE_3    = 3'd3,
        RULE_4    = 3'd4,
        RULE_5    = 3'd5
    } rule_t;

    typedef struct packed {
        logic [1:0] p0;
        logic [1:0] q0;
    } topup_t;

    // Bitwise half-add: p|q plus p&q equals p+q, so the pair's sum is kept
    // while every carry bit ends up under a set sum bit.
    function automatic topup_t topup_f(input logic [1:0] p, input logic [1:0] q);
        topup_t t;
        t.p0 = p | q;
        t.q0 = p & q;
        return t;
    endfunction

endpackage

// File: rtl/squeezer_rule_pipe_if.sv
// Beat-level handshake bundle between the carry-save accumulator, the rule
// pipeline and the squeezer datapath. slave = pipeline view, master = driver.
interface squeezer_rule_pipe_if
    import squeezer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
);

    logic                    in_valid;
    logic                    in_ready;
    logic [TAG_W-1:0]        in_tag;
    logic [2*LANES-1:0]      p_top;
    logic [2*LANES-1:0]      q_top;
    logic [LANES-1:0]        r2;

    logic                    out_valid;
    logic                    out_ready;
    logic [TAG_W-1:0]        out_tag;
    logic [RULE_W*LANES-1:0] rule;
    logic [2*LANES-1:0]      p_out;
    logic [2*LANES-1:0]      q_out;

    modport slave (
        input  in_valid, in_tag, p_top, q_top, r2, out_ready,
        output in_ready, out_valid, out_tag, rule, p_out, q_out
    );

    modport master (
        output in_valid, in_tag, p_top, q_top, r2, out_ready,
        input  in_ready, out_valid, out_tag, rule, p_out, q_out
    );

endinterface

// File: rtl/squeezer_rule_lane.sv
// One lane of the rule generator: topup of the raw top bits (feeds stage 1)
// and rule decode of the already-normalised, registered bits (feeds stage 2).
module squeezer_rule_lane
    import squeezer_pkg::*;
(
    input  logic [1:0] p_in,
    input  logic [1:0] q_in,
    output logic [1:0] p0_out,
    output logic [1:0] q0_out,
    input  logic [1:0] p0_reg,
    input  logic       q0l_reg,
    input  logic       r2_reg,
    output rule_t      rule_out
);

    topup_t norm;

    // Normalise the incoming sum/carry pair.
    always_comb begin
        norm   = topup_f(p_in, q_in);
        p0_out = norm.p0;
        q0_out = norm.q0;
    end

    // Priority decode of the squeeze rule; rules 6 and 7 are unreachable.
    always_comb begin
        rule_out = RULE_IDLE;
        if (!p0_reg[1]) begin
            rule_out = RULE_1;
        end else if (q0l_reg) begin
            rule_out = RULE_2;
        end else if (!r2_reg && p0_reg[0]) begin
            rule_out = RULE_3;
        end else if (!r2_reg) begin
            rule_out = RULE_4;
        end else if (!p0_reg[0]) begin
            rule_out = RULE_5;
        end
    end

endmodule

// File: rtl/squeezer_rule_pipe.sv
// Two-stage, multi-lane squeeze rule generator with valid/ready per stage.
// S1 holds topped-up bits, S2 holds the decoded rules. Optional per-rule
// saturating statistics are built when SQUEEZER_RULE_STATS_EN is defined.
module squeezer_rule_pipe
    import squeezer_pkg::*;
#(
    parameter int N     = 512,
    parameter int LANES = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    squeezer_rule_pipe_if.slave  bus,
    input  logic                 stats_clr,
    output logic [6*CNT_W-1:0]   stats
);

    // Only the top two bits of the N-bit operands ever reach this block.
    localparam int n_unused = N;

    logic                    s1_adv;
    logic                    s2_adv;
    logic [2*LANES-1:0]      p0_in;
    logic [2*LANES-1:0]      q0_in;
    logic [RULE_W*LANES-1:0] rule_comb;

    logic                    vld_p1_q, vld_p1_d;
    logic [2*LANES-1:0]      p0_p1_q, p0_p1_d;
    logic [2*LANES-1:0]      q0_p1_q, q0_p1_d;
    logic [LANES-1:0]        r2_p1_q, r2_p1_d;
    logic [TAG_W-1:0]        tag_p1_q, tag_p1_d;

    logic                    vld_p2_q, vld_p2_d;
    logic [RULE_W*LANES-1:0] rule_p2_q, rule_p2_d;
    logic [2*LANES-1:0]      p0_p2_q, p0_p2_d;
    logic [2*LANES-1:0]      q0_p2_q, q0_p2_d;
    logic [TAG_W-1:0]        tag_p2_q, tag_p2_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rule_t lane_rule;
        squeezer_rule_lane u_lane (
            .p_in     (bus.p_top[2*k +: 2]),
            .q_in     (bus.q_top[2*k +: 2]),
            .p0_out   (p0_in[2*k +: 2]),
            .q0_out   (q0_in[2*k +: 2]),
            .p0_reg   (p0_p1_q[2*k +: 2]),
            .q0l_reg  (q0_p1_q[2*k]),
            .r2_reg   (r2_p1_q[k]),
            .rule_out (lane_rule)
        );
        assign rule_comb[RULE_W*k +: RULE_W] = lane_rule;
    end

    // Stage advance conditions; out_ready -> in_ready is the only comb path.
    always_comb begin
        s2_adv = bus.out_ready || !vld_p2_q;
        s1_adv = s2_adv || !vld_p1_q;
    end

    assign bus.in_ready = s1_adv;

    // ---- input -> S1 boundary ----
    // S1 next state: capture a new beat on advance, flush empties the stage.
    always_comb begin
        vld_p1_d = vld_p1_q;
        p0_p1_d  = p0_p1_q;
        q0_p1_d  = q0_p1_q;
        r2_p1_d  = r2_p1_q;
        tag_p1_d = tag_p1_q;
        if (s1_adv) begin
            vld_p1_d = bus.in_valid;
            if (bus.in_valid) begin
                p0_p1_d  = p0_in;
                q0_p1_d  = q0_in;
                r2_p1_d  = bus.r2;
                tag_p1_d = bus.in_tag;
            end
        end
        if (flush) begin
            vld_p1_d = 1'b0;
        end
    end

    // S1 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    // S1 payload; only meaningful while vld_p1_q is set.
    always_ff @(posedge clk) begin
        p0_p1_q  <= p0_p1_d;
        q0_p1_q  <= q0_p1_d;
        r2_p1_q  <= r2_p1_d;
        tag_p1_q <= tag_p1_d;
    end

    // ---- S1 -> S2 boundary ----
    // S2 next state: take the decoded S1 beat on advance, hold otherwise.
    always_comb begin
        vld_p2_d  = vld_p2_q;
        rule_p2_d = rule_p2_q;
        p0_p2_d   = p0_p2_q;
        q0_p2_d   = q0_p2_q;
        tag_p2_d  = tag_p2_q;
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                rule_p2_d = rule_comb;
                p0_p2_d   = p0_p1_q;
                q0_p2_d   = q0_p1_q;
                tag_p2_d  = tag_p1_q;
            end
        end
        if (flush) begin
            vld_p2_d = 1'b0;
        end
    end

    // S2 registers drive the outputs directly and reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            rule_p2_q <= '0;
            p0_p2_q   <= '0;
            q0_p2_q   <= '0;
            tag_p2_q  <= '0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            rule_p2_q <= rule_p2_d;
            p0_p2_q   <= p0_p2_d;
            q0_p2_q   <= q0_p2_d;
            tag_p2_q  <= tag_p2_d;
        end
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.rule      = rule_p2_q;
    assign bus.p_out     = p0_p2_q;
    assign bus.q_out     = q0_p2_q;
    assign bus.out_tag   = tag_p2_q;

`ifdef SQUEEZER_RULE_STATS_EN
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic              out_fire;
    logic [31:0]       hits  [6];
    logic [CNT_W-1:0]  cnt_q [6];
    logic [CNT_W-1:0]  cnt_d [6];

    function automatic logic [CNT_W-1:0] sat_add_f(input logic [CNT_W-1:0] a,
                                                   input logic [31:0]      inc);
        logic [31:0] s;
        s = 32'(a) + inc;
        if (s > CNT_MAX) begin
            s = CNT_MAX;
        end
        return CNT_W'(s);
    endfunction

    assign out_fire = vld_p2_q && bus.out_ready;

    // Per-rule lane hit counts on an output handshake; clear beats increment.
    always_comb begin
        for (int r = 0; r < 6; r++) begin
            hits[r] = '0;
            for (int k = 0; k < LANES; k++) begin
                if (rule_p2_q[RULE_W*k +: RULE_W] == RULE_W'(r)) begin
                    hits[r] = hits[r] + 32'd1;
                end
            end
            cnt_d[r] = cnt_q[r];
            if (stats_clr) begin
                cnt_d[r] = '0;
            end else if (out_fire) begin
                cnt_d[r] = sat_add_f(cnt_q[r], hits[r]);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 6; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 6; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Flatten counters onto the stats bus, rule r at [r*CNT_W +: CNT_W].
    always_comb begin
        stats = '0;
        for (int r = 0; r < 6; r++) begin
            stats[r*CNT_W +: CNT_W] = cnt_q[r];
        end
    end
`else
    logic stats_clr_unused;
    assign stats_clr_unused = stats_clr;
    assign stats            = '0;
`endif

endmodule

// File: tb/tb_squeezer_rule_pipe.sv
// Directed bench for squeezer_rule_pipe: rule table, lane independence,
// backpressure ordering, flush, async reset and (with the macro) statistics.
module tb_squeezer_rule_pipe;
    import squeezer_pkg::*;

    localparam int N     = 512;
    localparam int LANES = 4;
    localparam int TAG_W = 4;
`ifdef SQUEEZER_RULE_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                stats_clr = 1'b0;
    logic [6*CNT_W-1:0]  stats;

    squeezer_rule_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    squeezer_rule_pipe #(.N(N), .LANES(LANES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stats_clr (stats_clr),
        .stats     (stats)
    );

    always #5 clk = ~clk;

    // Rule table rows: raw p, q, r2 and hand-derived rule / normalised bits.
    logic [1:0] row_p    [6] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [1:0] row_q    [6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic       row_r2   [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [2:0] row_rule [6] = '{3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd0};
    logic [1:0] row_po   [6] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [1:0] row_qo   [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_tag   = '0;
        bus.p_top    = '0;
        bus.q_top    = '0;
        bus.r2       = '0;
    endtask

    // Lane 0 gets table row r, lanes 1..3 get p=q=0 (rule 1).
    task automatic drive_row(input int r, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_tag   = tag;
        bus.p_top    = {6'b0, row_p[r]};
        bus.q_top    = {6'b0, row_q[r]};
        bus.r2       = {3'b0, row_r2[r]};
    endtask

    // One beat into an empty pipe with out_ready high; checks 2-edge latency.
    task automatic send_one(input string name, input int r, input logic [TAG_W-1:0] tag);
        bus.out_ready = 1'b1;
        drive_row(r, tag);
        #1;
        check_vec({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        idle_inputs();
        check_vec({name, "_lat1_vld"}, 32'(bus.out_valid), 32'd0);
        step();
        check_vec({name, "_vld"},   32'(bus.out_valid), 32'd1);
        check_vec({name, "_rule"},  32'(bus.rule[2:0]), 32'(row_rule[r]));
        check_vec({name, "_p_out"}, 32'(bus.p_out[1:0]), 32'(row_po[r]));
        check_vec({name, "_q_out"}, 32'(bus.q_out[1:0]), 32'(row_qo[r]));
        check_vec({name, "_tag"},   32'(bus.out_tag), 32'(tag));
        step();
        check_vec({name, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_rule;
        logic [7:0]  exp_po;
        logic [7:0]  exp_qo;
        int          sent;
        int          rcv;
        int          stalls;

        idle_inputs();
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_vec("rst_rule",      32'(bus.rule), 32'd0);
        check_vec("rst_p_out",     32'(bus.p_out), 32'd0);
        check_vec("rst_q_out",     32'(bus.q_out), 32'd0);
        check_vec("rst_out_tag",   32'(bus.out_tag), 32'd0);
        for (int r = 0; r < 6; r++) begin
            check_vec("rst_stats", 32'(stats[r*CNT_W +: CNT_W]), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check_vec("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Rule table, one beat per row on lane 0
        for (int r = 0; r < 6; r++) begin
            send_one($sformatf("row%0d", r), r, TAG_W'(r));
        end

        // Lane independence: lanes 0..3 take rows 1..4, tag 0xA
        exp_rule = '0;
        exp_po   = '0;
        exp_qo   = '0;
        bus.in_valid = 1'b1;
        bus.in_tag   = 4'hA;
        for (int k = 0; k < LANES; k++) begin
            bus.p_top[2*k +: 2] = row_p[k+1];
            bus.q_top[2*k +: 2] = row_q[k+1];
            bus.r2[k]           = row_r2[k+1];
            exp_rule[3*k +: 3]  = row_rule[k+1];
            exp_po[2*k +: 2]    = row_po[k+1];
            exp_qo[2*k +: 2]    = row_qo[k+1];
        end
        step();
        idle_inputs();
        step();
        check_vec("lanes_vld",   32'(bus.out_valid), 32'd1);
        check_vec("lanes_rule",  32'(bus.rule), 32'(exp_rule));
        check_vec("lanes_rule_lit", 32'(bus.rule), 32'h000B1A);
        check_vec("lanes_p_out", 32'(bus.p_out), 32'(exp_po));
        check_vec("lanes_q_out", 32'(bus.q_out), 32'(exp_qo));
        check_vec("lanes_tag",   32'(bus.out_tag), 32'hA);
        step();

        // Backpressure: 8 beats, out_ready toggling 1,0,1,0...
        sent   = 0;
        rcv    = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            if (sent < 8) begin
                drive_row(sent % 6, TAG_W'(sent));
            end else begin
                idle_inputs();
            end
            #1;
            if (bus.out_ready) begin
                check_vec("bp_ready_when_out_ready", 32'(bus.in_ready), 32'd1);
            end
            if (!bus.in_ready) begin
                stalls++;
                check_vec("bp_stall_only_when_full", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                check_vec("bp_order_tag", 32'(bus.out_tag), 32'(rcv));
                check_vec("bp_rule", 32'(bus.rule[2:0]), 32'(row_rule[rcv % 6]));
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
            end
            step();
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        check_vec("bp_all_received", 32'(rcv), 32'd8);
        check_vec("bp_saw_stall", 32'(stalls != 0), 32'd1);
        step();
        check_vec("bp_empty", 32'(bus.out_valid), 32'd0);

        // Flush with two beats in flight; a same-cycle input is discarded
        drive_row(0, 4'h1);
        step();
        drive_row(1, 4'h2);
        step();
        check_vec("fl_pre_vld", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        drive_row(2, 4'h3);
        step();
        flush = 1'b0;
        idle_inputs();
        check_vec("fl_vld_cleared", 32'(bus.out_valid), 32'd0);
        step();
        check_vec("fl_stays_empty", 32'(bus.out_valid), 32'd0);
        send_one("fl_post", 3, 4'h5);

        // Async reset between edges while a beat is held at the output
        bus.out_ready = 1'b0;
        drive_row(1, 4'h6);
        step();
        idle_inputs();
        step();
        check_vec("ar_pre_vld", 32'(bus.out_valid), 32'd1);
        check_vec("ar_pre_rule", 32'(bus.rule[2:0]), 32'd2);
        check_vec("ar_rdy_s1_empty", 32'(bus.in_ready), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("ar_vld", 32'(bus.out_valid), 32'd0);
        check_vec("ar_rule", 32'(bus.rule), 32'd0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check_vec("ar_in_ready", 32'(bus.in_ready), 32'd1);
        check_vec("ar_post_vld", 32'(bus.out_valid), 32'd0);

`ifdef SQUEEZER_RULE_STATS_EN
        // Statistics: 3 all-rule-1 beats -> 12, 5 beats -> saturate, clear
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int r = 0; r < 6; r++) begin
            check_vec("st_cleared", 32'(stats[r*CNT_W +: CNT_W]), 32'd0);
        end
        for (int b = 0; b < 3; b++) begin
            send_one("st_beat", 0, TAG_W'(b));
        end
        for (int r = 0; r < 6; r++) begin
            check_vec($sformatf("st_after3_r%0d", r), 32'(stats[r*CNT_W +: CNT_W]),
                      (r == 1) ? 32'd12 : 32'd0);
        end
        for (int b = 0; b < 2; b++) begin
            send_one("st_beat", 0, TAG_W'(b));
        end
        check_vec("st_saturated", 32'(stats[1*CNT_W +: CNT_W]), 32'd15);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check_vec("st_clr_zero", 32'(stats[1*CNT_W +: CNT_W]), 32'd0);
`else
        // Statistics disabled: stats stays zero and stats_clr has no effect
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int r = 0; r < 6; r++) begin
            check_vec("st_off_zero", 32'(stats[r*CNT_W +: CNT_W]), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
